// File: rtl/servo_angle_ramp_if.sv
// -----------------------------------------------------------------------------
// servo_angle_ramp_if
// Angle command channel into the servo ramp stage.
//   cmd_valid : an angle command is present (master -> slave)
//   cmd_angle : requested angle in degrees   (master -> slave)
//   cmd_ready : slave can accept a command   (slave -> master)
// A command transfers on a clock edge where cmd_valid and cmd_ready are both 1.
// -----------------------------------------------------------------------------
interface servo_angle_ramp_if;
    logic       cmd_valid;
    logic [7:0] cmd_angle;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_angle,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_angle,
        output cmd_ready
    );
endinterface

// File: rtl/servo_angle_ramp.sv
// -----------------------------------------------------------------------------
// servo_angle_ramp
// Converts an angle command into a PWM high-time and slews the generator's
// high-time toward it by at most STEP_CYC per PWM frame, then waits
// SETTLE_FRAMES frames before reporting completion.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   cmd    : angle command channel (valid/ready, slave side)
//   d      : high-time to PWM generator, in clocks
//   t      : period to PWM generator, constant PERIOD_CYC
//   busy   : a move or settle is in progress
//   done   : one-cycle pulse when a move has settled
//   err    : one-cycle pulse when a command angle is out of range
// -----------------------------------------------------------------------------
module servo_angle_ramp #(
    parameter int unsigned PERIOD_CYC    = 32'd1_000_000,
    parameter int unsigned MIN_CYC       = 32'd50_000,
    parameter int unsigned DEG_CYC       = 32'd278,
    parameter int unsigned MAX_CYC       = 32'd100_000,
    parameter int unsigned MAX_ANGLE     = 32'd180,
    parameter int unsigned HOME_CYC      = 32'd75_000,
    parameter int unsigned STEP_CYC      = 32'd500,
    parameter int unsigned SETTLE_FRAMES = 32'd10
) (
    input  logic               clk,
    input  logic               reset,
    servo_angle_ramp_if.slave  cmd,
    output logic [31:0]        d,
    output logic [31:0]        t,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] frame_cnt_r;
    logic        frame_tick_s;
    logic [31:0] target_r;
    logic [31:0] target_s;
    logic [31:0] d_r;
    logic [31:0] d_s;
    logic [31:0] settle_r;
    logic [31:0] settle_s;
    logic [31:0] settle_inc_s;
    logic [31:0] diff_s;
    logic [31:0] t_r;
    logic        ready_r;
    logic        ready_s;
    logic        busy_r;
    logic        busy_s;
    logic        done_r;
    logic        done_s;
    logic        err_r;
    logic        err_s;
    logic        handshake_s;
    logic        angle_bad_s;

    // Angle to high-time, saturated at MAX_CYC.
    function automatic logic [31:0] angle_to_cyc(input logic [7:0] angle);
        logic [31:0] raw;
        raw = MIN_CYC + ({24'd0, angle} * DEG_CYC);
        if (raw > MAX_CYC) begin
            angle_to_cyc = MAX_CYC;
        end else begin
            angle_to_cyc = raw;
        end
    endfunction

    // Distance between two high-times; larger minus smaller so it never wraps.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

    assign frame_tick_s = (frame_cnt_r == (PERIOD_CYC - 32'd1));
    assign handshake_s  = cmd.cmd_valid && ready_r;
    assign angle_bad_s  = ({24'd0, cmd.cmd_angle} > MAX_ANGLE);
    assign diff_s       = abs_diff(target_r, d_r);
    assign settle_inc_s = settle_r + 32'd1;

    assign cmd.cmd_ready = ready_r;
    assign d             = d_r;
    assign t             = t_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

    // Free-running PWM frame counter, independent of the move state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= 32'd0;
        end else if (frame_tick_s) begin
            frame_cnt_r <= 32'd0;
        end else begin
            frame_cnt_r <= frame_cnt_r + 32'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            target_r <= HOME_CYC;
            d_r      <= HOME_CYC;
            settle_r <= 32'd0;
        end else begin
            state_r  <= state_s;
            target_r <= target_s;
            d_r      <= d_s;
            settle_r <= settle_s;
        end
    end

    // Next-state, next-datapath and next-output decode.
    always_comb begin
        state_s  = state_r;
        target_s = target_r;
        d_s      = d_r;
        settle_s = settle_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    if (angle_bad_s) begin
                        err_s = 1'b1;
                    end else begin
                        target_s = angle_to_cyc(cmd.cmd_angle);
                        state_s  = ST_MOVE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (frame_tick_s) begin
                    // Within one step: land exactly; this also covers target == d.
                    if (diff_s <= STEP_CYC) begin
                        d_s      = target_r;
                        settle_s = 32'd0;
                        state_s  = ST_SETTLE;
                    end else if (target_r > d_r) begin
                        d_s = d_r + STEP_CYC;
                    end else begin
                        d_s = d_r - STEP_CYC;
                    end
                end else begin
                    state_s = ST_MOVE;
                end
            end
            ST_SETTLE: begin
                if (frame_tick_s) begin
                    settle_s = settle_inc_s;
                    if (settle_inc_s >= SETTLE_FRAMES) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Ready and busy follow the state being entered so they line up with done.
        ready_s = (state_s == ST_IDLE);
        busy_s  = !ready_s;
    end

    // Registered status outputs and constant period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            t_r     <= PERIOD_CYC;
        end else begin
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
            t_r     <= t_r;
        end
    end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// -----------------------------------------------------------------------------
// tb_servo_angle_ramp
// Directed and random angle commands; expected output events (d changes,
// done, err) are derived from the slewing rules with plain arithmetic, tagged
// with the clock edge at which they must appear, and compared by a monitor.
// -----------------------------------------------------------------------------
module tb_servo_angle_ramp;

    localparam int PERIOD = 100;
    localparam int MINC   = 10;
    localparam int MAXC   = 60;
    localparam int MAXA   = 50;
    localparam int HOME   = 35;
    localparam int STEP   = 4;
    localparam int SETTLE = 2;

    localparam int EV_D    = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int value;
        int edge_idx;
    } ev_t;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic [31:0] t;
    logic        busy;
    logic        done;
    logic        err;

    servo_angle_ramp_if cmd_if ();

    servo_angle_ramp #(
        .PERIOD_CYC    (32'd100),
        .MIN_CYC       (32'd10),
        .DEG_CYC       (32'd1),
        .MAX_CYC       (32'd60),
        .MAX_ANGLE     (32'd50),
        .HOME_CYC      (32'd35),
        .STEP_CYC      (32'd4),
        .SETTLE_FRAMES (32'd2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .d     (d),
        .t     (t),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 if (clk_en) clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt;
    ev_t  exp_q[$];
    int   model_d = HOME;
    int   busy_start = 0;
    int   busy_end = 0;
    int   last_t1 = 0;
    logic [31:0] prev_d = 32'd35;

    // Edges since reset release; edge k is the (k+1)-th rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input int kind, input int value, input int k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got kind=%0d value=%0d edge=%0d, required no event", kind, value, k);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value != value || e.edge_idx != k) begin
                n_errors++;
                $display("FAIL event: got kind=%0d value=%0d edge=%0d, required kind=%0d value=%0d edge=%0d",
                         kind, value, k, e.kind, e.value, e.edge_idx);
            end
        end
    endtask

    // Monitor: per-cycle status checks and event scoreboard.
    always @(negedge clk) begin
        int  k;
        bit  exp_busy;
        if (reset === 1'b1) begin
            k = edge_cnt - 1;
            exp_busy = (k >= busy_start) && (k < busy_end);
            check("busy", busy, exp_busy);
            check("cmd_ready", cmd_if.cmd_ready, !exp_busy);
            check("t", t, PERIOD);
            if (d !== prev_d) begin
                pop_check(EV_D, int'(d), k);
                prev_d = d;
            end
            if (done === 1'b1) pop_check(EV_DONE, 0, k);
            if (err === 1'b1)  pop_check(EV_ERR, 0, k);
        end
    end

    task automatic push_ev(input int kind, input int value, input int k);
        ev_t e;
        e.kind = kind;
        e.value = value;
        e.edge_idx = k;
        exp_q.push_back(e);
    endtask

    // Issue one command and record the responses it must produce.
    task automatic issue_cmd(input int angle);
        int h, tgt, cur, n, t1, guard;
        logic [31:0] a32;
        guard = 0;
        @(negedge clk);
        while (cmd_if.cmd_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got cmd_ready=%0d, required 1", cmd_if.cmd_ready);
            return;
        end
        a32 = angle;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_angle = a32[7:0];
        h = edge_cnt;
        if (angle > MAXA) begin
            push_ev(EV_ERR, 0, h);
        end else begin
            tgt = MINC + angle;
            if (tgt > MAXC) tgt = MAXC;
            t1 = (h % PERIOD == PERIOD - 1) ? h + PERIOD : h + (PERIOD - 1 - h % PERIOD);
            last_t1 = t1;
            cur = model_d;
            n = 0;
            do begin
                int prev;
                prev = cur;
                if ((tgt > cur ? tgt - cur : cur - tgt) <= STEP) cur = tgt;
                else if (tgt > cur) cur = cur + STEP;
                else cur = cur - STEP;
                n++;
                if (cur != prev) push_ev(EV_D, cur, t1 + PERIOD * (n - 1));
            end while (cur != tgt);
            push_ev(EV_DONE, 0, t1 + PERIOD * (n + SETTLE - 1));
            busy_start = h;
            busy_end = t1 + PERIOD * (n + SETTLE - 1);
            model_d = tgt;
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && (edge_cnt - 1) >= busy_end) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_d"}, d, HOME);
        check({tag, "_t"}, t, PERIOD);
        check({tag, "_ready"}, cmd_if.cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int guard;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_angle = 8'd0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #2 check_reset_values("reset_noclk");
        clk_en = 1'b1;
        #32;
        @(negedge clk);
        #1 reset = 1'b1;

        // Upward: 35 -> 55
        issue_cmd(45);
        wait_idle();
        // Downward: 55 -> 10
        issue_cmd(0);
        wait_idle();
        // Out of range
        issue_cmd(51);
        wait_idle();
        check("d_after_reject", d, 10);
        // Same angle, plus commands offered while busy
        issue_cmd(0);
        for (int i = 0; i < 5; i++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_angle = 8'd30;
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
        wait_idle();
        check("d_after_same", d, 10);

        // Random commands, including out-of-range angles
        for (int i = 0; i < 8; i++) begin
            issue_cmd(int'($urandom_range(0, 60)));
            wait_idle();
        end

        // Reset during a move: home 35 -> angle 45, interrupted at d=47
        @(negedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        model_d = HOME;
        prev_d = 32'd35;
        busy_start = 0;
        busy_end = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        issue_cmd(45);
        guard = 0;
        while ((edge_cnt - 1) < last_t1 + 2 * PERIOD + 5 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("d_before_midreset", d, 47);
        #2 reset = 1'b0;
        #1 check_reset_values("reset_midmove");
        exp_q.delete();
        model_d = HOME;
        prev_d = 32'd35;
        busy_start = 0;
        busy_end = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        issue_cmd(20);
        wait_idle();
        check("d_after_reset_move", d, 30);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
